data_mem_sweep: RTL and testbench
=================================

Name: data_mem_sweep

Overview:
Parametrised successor to the processor's single-port data memory. Generalised width/depth; adds a hardware clear sweep after reset, registered (1-cycle) reads with a valid strobe, write-first same-address bypass, and out-of-range detection. Sits between the datapath LDR/STR logic and the core array; the datapath must stall until ready=1.

Parameters:
W, 8, data width in bits
A, 8, address width in bits
DEPTH, 2**A, number of entries; must satisfy 1 <= DEPTH <= 2**A
CLR_VAL, 0, W-bit value written to every entry by the clear sweep

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-high reset
data_to_write  in  W  store data
addr  in  A  shared read/write address
read_enabled  in  1  read request (LDR)
write_enabled  in  1  write request (STR)
par_flip  in  1  test hook: invert stored parity on this write (used only with DMEM_PARITY_EN)
ready  out  1  1 = sweep done, requests accepted
rd_valid  out  1  1-cycle pulse: data_out holds the result of the previous cycle's read
data_out  out  W  registered read data
addr_err  out  1  1-cycle pulse: previous cycle's request had addr >= DEPTH
parity_err  out  1  1-cycle pulse with rd_valid on parity mismatch (tied 0 without macro)

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values while reset=1: state=CLEAR, sweep ptr=0, ready=0, rd_valid=0, data_out=0, addr_err=0, parity_err=0.
- Reset asserted mid-sweep or mid-operation restarts the sweep at ptr=0. The array is not cleared in the reset cycle itself.
- State CLEAR: each posedge with reset=0 writes CLR_VAL to core[ptr] and increments ptr.
- After the write of ptr=DEPTH-1, state goes to READY. ready rises DEPTH edges after the first edge with reset=0. Example: DEPTH=256 gives ready=1 after edge 256.
- In CLEAR, read_enabled and write_enabled are ignored: no write, rd_valid=0, addr_err=0.
- State READY, write: write_enabled=1 and addr<DEPTH writes core[addr]<=data_to_write at the edge.
- State READY, read: read_enabled=1 samples at the edge. data_out and rd_valid=1 appear after that edge, so latency is 1 cycle. Back-to-back reads give rd_valid=1 every cycle.
- With no read, rd_valid=0 and data_out holds its last value. It is not zeroed.
- Read and write to the same addr in the same cycle: write-first, data_out=data_to_write.
- Read and write to different addresses in the same cycle: both are performed.
- Out of range (addr>=DEPTH, possible only when DEPTH<2**A): the write is dropped and the array is unchanged. A read returns data_out=0 with rd_valid=1. addr_err pulses 1 cycle after the request edge.
- Stays in READY until reset. No other transitions.
- No X on outputs after the reset cycle.

Optional Feature:
Macro DMEM_PARITY_EN.
- Defined: each entry stores W+1 bits, the data plus an even-parity bit. The sweep stores the correct parity of CLR_VAL. A write with par_flip=1 stores inverted parity. On each read of an in-range address, parity_err=1 with rd_valid if the stored parity does not match. A write-first bypass read never flags.
- Not defined: entries are W bits, par_flip is ignored, parity_err is constant 0.

Test Plan:
- Reset then clear (DEPTH=256, CLR_VAL=8'hA5): hold reset 3 cycles, then release. ready=0 through edge 255 and ready=1 after edge 256. Reading every address returns 8'hA5 with rd_valid each cycle.
- Write/read latency: write 8'h3C to addr 8'h10, next cycle read 8'h10. data_out=8'h3C with rd_valid=1 exactly one edge after the read edge; the cycle after that, rd_valid=0 and data_out still 8'h3C.
- Same-cycle bypass: core[5]=8'h11; read and write 8'h77 to addr 5 together. data_out=8'h77. A later read of 5 returns 8'h77.
- Reset mid-sweep: assert reset at sweep ptr=100 for 1 cycle. ready rises 256 edges after release. Requests issued during the sweep (write 8'hFF to addr 3) are ignored, and addr 3 reads CLR_VAL.
- Out of range (DEPTH=200, A=8): write 8'h55 to addr 210, then read 210. addr_err pulses after each request, the read gives data_out=0 and rd_valid=1, and entries 0..199 are unchanged.
- DMEM_PARITY_EN: write 8'h0F to addr 7 with par_flip=1, then read 7. data_out=8'h0F and parity_err=1. Rewrite with par_flip=0 and read again: parity_err=0.

Source files
------------

// File: rtl/data_mem_sweep.sv
// Parametrised single-port data memory with a post-reset clear sweep, registered
// reads, write-first bypass and out-of-range flagging. Optional macro: DMEM_PARITY_EN.
module data_mem_sweep #(
    parameter int unsigned    W       = 8,
    parameter int unsigned    A       = 8,
    parameter int unsigned    DEPTH   = 2**A,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] data_to_write,
    input  logic [A-1:0] addr,
    input  logic         read_enabled,
    input  logic         write_enabled,
    input  logic         par_flip,
    output logic         ready,
    output logic         rd_valid,
    output logic [W-1:0] data_out,
    output logic         addr_err,
    output logic         parity_err
);

`ifdef DMEM_PARITY_EN
    localparam int unsigned EW = W + 1;
`else
    localparam int unsigned EW = W;
`endif

    localparam logic [A-1:0] LAST      = A'(DEPTH - 1);
    localparam logic [A:0]   DEPTH_EXT = (A+1)'(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t         state, state_nx;
    logic [A-1:0]   ptr, ptr_nx;
    logic           mem_we;
    logic [A-1:0]   mem_waddr;
    logic [EW-1:0]  mem_wdata;
    logic [EW-1:0]  clr_word;
    logic [EW-1:0]  wr_word;
    logic [EW-1:0]  rd_word;
    logic           in_range;
    logic           par_bad;

    logic [EW-1:0]  core [DEPTH];

    // Stored word carries an even-parity bit above the data when parity is enabled.
`ifdef DMEM_PARITY_EN
    assign clr_word = {^CLR_VAL, CLR_VAL};
    assign wr_word  = {(^data_to_write) ^ par_flip, data_to_write};
    assign par_bad  = ^rd_word;
`else
    logic unused_par_flip;
    assign unused_par_flip = par_flip;
    assign clr_word = CLR_VAL;
    assign wr_word  = data_to_write;
    assign par_bad  = 1'b0;
`endif

    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign rd_word  = core[addr];
    assign ready    = (state == READY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        mem_we    = 1'b0;
        mem_waddr = ptr;
        mem_wdata = clr_word;
        case (state)
            CLEAR: begin
                mem_we = 1'b1;
                if (ptr == LAST) begin
                    state_nx = READY;
                    ptr_nx   = '0;
                end else begin
                    ptr_nx = ptr + 1'b1;
                end
            end
            READY: begin
                if (write_enabled && in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr;
                    mem_wdata = wr_word;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    // The array is never written in a reset cycle; the sweep restarts afterwards.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            core[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid   <= 1'b0;
            data_out   <= '0;
            addr_err   <= 1'b0;
            parity_err <= 1'b0;
        end else if (state == READY) begin
            rd_valid   <= read_enabled;
            addr_err   <= (read_enabled || write_enabled) && !in_range;
            parity_err <= 1'b0;
            if (read_enabled) begin
                if (!in_range) begin
                    data_out <= '0;
                end else if (write_enabled) begin
                    data_out <= data_to_write;
                end else begin
                    data_out   <= rd_word[W-1:0];
                    parity_err <= par_bad;
                end
            end
        end else begin
            rd_valid   <= 1'b0;
            addr_err   <= 1'b0;
            parity_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_sweep.sv
// Randomised and directed bench for data_mem_sweep against a behavioural model
// (DEPTH=200 so out-of-range addresses exist). Honours DMEM_PARITY_EN.
module tb_data_mem_sweep;

    localparam int unsigned W     = 8;
    localparam int unsigned A     = 8;
    localparam int unsigned DEPTH = 200;
    localparam logic [7:0]  CLR   = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_to_write = '0;
    logic [7:0] addr = '0;
    logic       read_enabled = 1'b0;
    logic       write_enabled = 1'b0;
    logic       par_flip = 1'b0;
    logic       ready, rd_valid, addr_err, parity_err;
    logic [7:0] data_out;

    data_mem_sweep #(
        .W       (W),
        .A       (A),
        .DEPTH   (DEPTH),
        .CLR_VAL (CLR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_to_write (data_to_write),
        .addr          (addr),
        .read_enabled  (read_enabled),
        .write_enabled (write_enabled),
        .par_flip      (par_flip),
        .ready         (ready),
        .rd_valid      (rd_valid),
        .data_out      (data_out),
        .addr_err      (addr_err),
        .parity_err    (parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mem  [DEPTH];
    logic       flip [DEPTH];
    logic       m_ready = 1'b0;
    int         sweep_edges = 0;
    logic       e_rv = 1'b0, e_ae = 1'b0, e_pe = 1'b0;
    logic [7:0] e_do = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic re, input logic we,
                        input logic [7:0] a, input logic [7:0] d, input logic pf);
        reset         = rst;
        read_enabled  = re;
        write_enabled = we;
        addr          = a;
        data_to_write = d;
        par_flip      = pf;
        @(posedge clk);
        if (rst) begin
            m_ready = 1'b0; sweep_edges = 0;
            e_rv = 1'b0; e_ae = 1'b0; e_pe = 1'b0; e_do = '0;
        end else if (!m_ready) begin
            e_rv = 1'b0; e_ae = 1'b0; e_pe = 1'b0;
            sweep_edges++;
            if (sweep_edges == DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i]  = CLR;
                    flip[i] = 1'b0;
                end
            end
        end else begin
            e_rv = re;
            e_ae = (re || we) && (int'(a) >= DEPTH);
            e_pe = 1'b0;
            if (re) begin
                if (int'(a) >= DEPTH) e_do = '0;
                else if (we) e_do = d;
                else begin
                    e_do = mem[a];
`ifdef DMEM_PARITY_EN
                    e_pe = flip[a];
`endif
                end
            end
            if (we && int'(a) < DEPTH) begin
                mem[a]  = d;
                flip[a] = pf;
            end
        end
        #1;
        check("ready", 32'(ready), 32'(m_ready));
        check("rd_valid", 32'(rd_valid), 32'(e_rv));
        check("data_out", 32'(data_out), 32'(e_do));
        check("addr_err", 32'(addr_err), 32'(e_ae));
        check("parity_err", 32'(parity_err), 32'(e_pe));
    endtask

    task automatic rand_step(input logic allow_flip);
        logic [7:0] a;
        a = 8'($urandom_range(0, 255));
        step(1'b0, 1'($urandom), 1'($urandom), a, 8'($urandom),
             allow_flip & ($urandom_range(0, 7) == 0));
    endtask

    initial begin
        // Reset held three cycles, then a partial sweep with random requests
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 100; i++) rand_step(1'b1);
        // Mid-sweep reset; writes of FF to addr 3 during the new sweep must be dropped
        step(1'b1, 1'b1, 1'b1, 8'd3, 8'hFF, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, 8'd3, 8'hFF, 1'b0);
        check("ready_after_sweep", 32'(ready), 32'd1);

        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(i), '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'd3, '0, 1'b0);
        check("addr3_cleared", 32'(data_out), 32'(CLR));

        // Write then read latency, then data hold
        step(1'b0, 1'b0, 1'b1, 8'h10, 8'h3C, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b0);
        check("lat_data", 32'(data_out), 32'h3C);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("hold_data", 32'(data_out), 32'h3C);

        // Same-cycle write-first bypass
        step(1'b0, 1'b0, 1'b1, 8'd5, 8'h11, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'd5, 8'h77, 1'b0);
        check("bypass", 32'(data_out), 32'h77);
        step(1'b0, 1'b1, 1'b0, 8'd5, '0, 1'b0);

        // Out of range write and read, then confirm array intact
        step(1'b0, 1'b0, 1'b1, 8'd210, 8'h55, 1'b0);
        check("oor_wr_err", 32'(addr_err), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'd210, '0, 1'b0);
        check("oor_rd_err", 32'(addr_err), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'd199, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'd200, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(i), '0, 1'b0);

        // Parity flip then clean rewrite
        step(1'b0, 1'b0, 1'b1, 8'd7, 8'h0F, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'd7, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'd7, 8'h0F, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'd7, '0, 1'b0);

        for (int i = 0; i < 3000; i++) rand_step(1'b1);
        // Final reset to confirm outputs return to their reset values
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < DEPTH + 5; i++) rand_step(1'b0);
        for (int i = 0; i < 500; i++) rand_step(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
